// File: rtl/button_auto_repeat_if.sv
// Button auto-repeat handshake bundle: timebase, enable and button level in,
// increment pulse and repeat status out.
interface button_auto_repeat_if;
    logic i_Tick;
    logic i_Enable;
    logic i_Signal;
    logic o_Pulse;
    logic o_Repeating;
    logic o_Fast;

    modport master (
        output i_Tick, i_Enable, i_Signal,
        input  o_Pulse, o_Repeating, o_Fast
    );

    modport slave (
        input  i_Tick, i_Enable, i_Signal,
        output o_Pulse, o_Repeating, o_Fast
    );
endinterface

// File: rtl/button_auto_repeat.sv
// Turns a debounced button level into increment pulses: one on press, then
// slow auto-repeat, then fast auto-repeat after FAST_AFTER slow repeats.
module button_auto_repeat #(
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 200,
    parameter int FAST_AFTER   = 5,
    parameter int FAST_TICKS   = 50,
    parameter int CNT_WIDTH    = 10
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    button_auto_repeat_if.slave bus
);
    localparam int REP_W = $clog2(FAST_AFTER + 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] FAST_LAST   = CNT_WIDTH'(FAST_TICKS - 1);
    localparam logic [REP_W-1:0]     REP_LAST    = REP_W'(FAST_AFTER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT,
        S_FAST,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic                 pulse_q, pulse_d;
    logic                 repeating_q, repeating_d;
    logic                 fast_q, fast_d;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rep_q       <= '0;
            pulse_q     <= 1'b0;
            repeating_q <= 1'b0;
            fast_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            pulse_q     <= pulse_d;
            repeating_q <= repeating_d;
            fast_q      <= fast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        pulse_d = 1'b0;

        if (!bus.i_Enable) begin
            // A button still held when disabled must be released before it can fire again
            state_d = bus.i_Signal ? S_WAIT : S_IDLE;
            cnt_d   = '0;
            rep_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_Signal) begin
                        pulse_d = 1'b1;
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end
                end
                S_HOLD, S_REPEAT, S_FAST: begin
                    if (!bus.i_Signal) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        rep_d   = '0;
                    end else if (bus.i_Tick) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (state_q == S_HOLD && cnt_q == HOLD_LAST) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            rep_d   = '0;
                            state_d = S_REPEAT;
                        end else if (state_q == S_REPEAT && cnt_q == REPEAT_LAST) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            rep_d   = rep_q + REP_W'(1);
                            if (rep_q == REP_LAST) state_d = S_FAST;
                        end else if (state_q == S_FAST && cnt_q == FAST_LAST) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.i_Signal) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rep_d   = '0;
                end
            endcase
        end

        repeating_d = (state_d == S_REPEAT) || (state_d == S_FAST);
        fast_d      = (state_d == S_FAST);
    end

    assign bus.o_Pulse     = pulse_q;
    assign bus.o_Repeating = repeating_q;
    assign bus.o_Fast      = fast_q;
endmodule

// File: tb/tb_button_auto_repeat.sv
// Bench for button_auto_repeat: directed scenarios plus random stimulus, all
// checked against a tick-count model of the repeat schedule.
module tb_button_auto_repeat;
    localparam int H  = 4;
    localparam int R  = 2;
    localparam int F  = 3;
    localparam int FT = 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   npulse;

    button_auto_repeat_if bus ();

    button_auto_repeat #(
        .HOLD_TICKS  (H),
        .REPEAT_TICKS(R),
        .FAST_AFTER  (F),
        .FAST_TICKS  (FT),
        .CNT_WIDTH   (10)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: count ticks seen while held; pulses fall on fixed tick indices.
    bit active, blocked;
    int k;
    bit exp_pulse, exp_rep, exp_fast;

    function automatic bit fires(input int kk);
        if (kk == H) return 1'b1;
        if (kk > H && kk <= H + R * F) return ((kk - H) % R) == 0;
        if (kk > H + R * F) return ((kk - H - R * F) % FT) == 0;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0; blocked = 0; k = 0;
            exp_pulse = 0; exp_rep = 0; exp_fast = 0;
        end else begin
            exp_pulse = 0;
            if (!bus.i_Enable) begin
                active = 0; k = 0; blocked = bus.i_Signal;
            end else if (blocked) begin
                if (!bus.i_Signal) blocked = 0;
            end else if (!active) begin
                if (bus.i_Signal) begin
                    active = 1; k = 0; exp_pulse = 1;
                end
            end else if (!bus.i_Signal) begin
                active = 0; k = 0;
            end else if (bus.i_Tick) begin
                k++;
                exp_pulse = fires(k);
            end
            exp_rep  = active && k >= H;
            exp_fast = active && k >= H + R * F;
        end
    end

    always @(negedge clk) begin
        chk("pulse", 32'(bus.o_Pulse), 32'(exp_pulse));
        chk("repeating", 32'(bus.o_Repeating), 32'(exp_rep));
        chk("fast", 32'(bus.o_Fast), 32'(exp_fast));
        if (bus.o_Pulse) npulse++;
    end

    task automatic drive(input logic s, input logic e, input logic t);
        @(posedge clk);
        #3;
        bus.i_Signal = s;
        bus.i_Enable = e;
        bus.i_Tick   = t;
    endtask

    task automatic ticks(input int n, input logic s, input logic e);
        repeat (n) begin
            drive(s, e, 1'b1);
            repeat (9) drive(s, e, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (3) drive(bus.i_Signal, bus.i_Enable, 1'b0);
    endtask

    int base;
    bit s_r, e_r;

    initial begin
        n_cmp = 0; n_bad = 0; npulse = 0;
        rst = 1'b1;
        bus.i_Signal = 1'b1;
        bus.i_Enable = 1'b1;
        bus.i_Tick   = 1'b0;

        // 1: outputs quiet under reset with button held, then one press pulse
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pulse", 32'(bus.o_Pulse), 0);
        chk("rst_rep", 32'(bus.o_Repeating), 0);
        chk("rst_fast", 32'(bus.o_Fast), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        base = npulse;
        @(posedge clk);
        #1;
        chk("rel_pulse_hi", 32'(bus.o_Pulse), 1);
        @(posedge clk);
        #1;
        chk("rel_pulse_lo", 32'(bus.o_Pulse), 0);
        drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("rel_count", 32'(npulse - base), 1);

        // 2: short press
        base = npulse;
        drive(1'b1, 1'b1, 1'b0);
        ticks(2, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("short_count", 32'(npulse - base), 1);

        // 3: long hold into fast rate
        base = npulse;
        drive(1'b1, 1'b1, 1'b0);
        ticks(15, 1'b1, 1'b1);
        chk("hold_fast", 32'(bus.o_Fast), 1);
        drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("hold_count", 32'(npulse - base), 10);

        // 4: release coincident with a terminal tick in REPEAT
        base = npulse;
        drive(1'b1, 1'b1, 1'b0);
        ticks(5, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        #1;
        chk("relterm_rep", 32'(bus.o_Repeating), 0);
        settle();
        chk("relterm_count", 32'(npulse - base), 2);

        // 5: disable while held, re-enable held, then release and press
        base = npulse;
        drive(1'b1, 1'b1, 1'b0);
        ticks(5, 1'b1, 1'b1);
        ticks(3, 1'b1, 1'b0);
        ticks(6, 1'b1, 1'b1);
        chk("dis_count", 32'(npulse - base), 2);
        drive(1'b0, 1'b1, 1'b0);
        settle();
        drive(1'b1, 1'b1, 1'b0);
        settle();
        drive(1'b0, 1'b1, 1'b0);
        settle();
        chk("reen_count", 32'(npulse - base), 3);

        // 6: async reset in FAST, release with button held
        drive(1'b1, 1'b1, 1'b0);
        ticks(12, 1'b1, 1'b1);
        chk("pre_rst_fast", 32'(bus.o_Fast), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pulse", 32'(bus.o_Pulse), 0);
        chk("async_rep", 32'(bus.o_Repeating), 0);
        chk("async_fast", 32'(bus.o_Fast), 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        base = npulse;
        settle();
        chk("rst_press", 32'(npulse - base), 1);
        ticks(4, 1'b1, 1'b1);
        chk("rst_hold_count", 32'(npulse - base), 2);
        chk("rst_hold_rep", 32'(bus.o_Repeating), 1);
        drive(1'b0, 1'b1, 1'b0);
        settle();

        // random: sticky button and enable, periodic or random ticks
        s_r = 0;
        e_r = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) s_r = ~s_r;
            if ($urandom_range(0, 99) == 0) e_r = ~e_r;
            if (c >= 1500 && $urandom_range(0, 399) == 0) s_r = ~s_r;
            drive(s_r, e_r, (c < 1500) ? (c % 5 == 0) : ($urandom_range(0, 5) == 0));
        end
        drive(1'b0, 1'b1, 1'b0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
